// File: rtl/ip_address_matcher.sv
// rtl/ip_address_matcher.sv - streaming IPv4 target-address detector with 2-cycle passthrough
module ip_address_matcher (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic [31:0] ip_in,
  input  logic [31:0] data_in,
  output logic        match,
  output logic [31:0] data_out
);

  // Two-word history: cur is the newest word, prev the one before it.
  logic [31:0] cur;
  logic [31:0] prev;
  logic        match_r;

  // Search window and per-byte-offset compare results.
  logic [63:0] window;
  logic [4:0]  lane_eq;
  logic        hit;

  // Compare the target against every 32-bit slice of the window on a byte boundary.
  // Offsets 1-3 catch an address straddling prev (low bytes) and cur (high bytes);
  // offset 4 is the aligned current word, offset 0 the aligned previous word.
  always_comb begin
    window  = {cur, prev};
    lane_eq = '0;
    for (int i = 0; i < 5; i++) begin
      lane_eq[i] = (window[8*i +: 32] == ip_in);
    end
    // A zero target means no filter is programmed; an idle zero stream must not match.
    hit = (ip_in != 32'd0) && (|lane_eq);
  end

  // Word history, sticky match flag; reset beats clear, clear beats normal update.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cur     <= 32'd0;
      prev    <= 32'd0;
      match_r <= 1'b0;
    end else if (clear) begin
      cur     <= 32'd0;
      prev    <= 32'd0;
      match_r <= 1'b0;
    end else begin
      cur     <= data_in;
      prev    <= cur;
      match_r <= match_r | hit;
    end
  end

  assign data_out = prev;
  assign match    = match_r;

endmodule

// File: tb/tb_ip_address_matcher.sv
// tb/tb_ip_address_matcher.sv - scoreboard bench for ip_address_matcher
module tb_ip_address_matcher;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic [31:0] ip_in;
  logic [31:0] data_in;
  logic        match;
  logic [31:0] data_out;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_do_q[$];
  logic        exp_m_q[$];

  localparam logic [31:0] IP = 32'hC0A80101;

  ip_address_matcher dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .ip_in    (ip_in),
    .data_in  (data_in),
    .match    (match),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat, queue what the outputs must be after the edge, then pop and compare.
  task automatic beat(input logic [31:0] d, input logic clr,
                      input logic [31:0] exp_do, input logic exp_m, input string nm);
    logic [31:0] e_do;
    logic        e_m;
    data_in = d;
    clear   = clr;
    exp_do_q.push_back(exp_do);
    exp_m_q.push_back(exp_m);
    @(posedge clk);
    #1;
    e_do = exp_do_q.pop_front();
    e_m  = exp_m_q.pop_front();
    tests_run++;
    if (data_out !== e_do) begin
      tests_failed++;
      $display("FAIL %s data_out: got %h expected %h", nm, data_out, e_do);
    end
    tests_run++;
    if (match !== e_m) begin
      tests_failed++;
      $display("FAIL %s match: got %b expected %b", nm, match, e_m);
    end
  endtask

  task automatic test_reset();
    n_rst   = 1'b0;
    clear   = 1'b0;
    ip_in   = IP;
    data_in = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    tests_run++;
    if (data_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset data_out: got %h expected %h", data_out, 32'd0);
    end
    tests_run++;
    if (match !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset match: got %b expected %b", match, 1'b0);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_aligned();
    ip_in = IP;
    beat(32'h0,  1'b1, 32'h0, 1'b0, "aligned_clear");
    beat(IP,     1'b0, 32'h0, 1'b0, "aligned_e1");
    beat(32'h0,  1'b0, IP,    1'b1, "aligned_e2");
    beat(32'h0,  1'b0, 32'h0, 1'b1, "aligned_e3");
    beat(32'h0,  1'b0, 32'h0, 1'b1, "aligned_e4");
  endtask

  // Two words, then zeros: w1 alone never matches, the hit (if any) shows one edge after w2.
  task automatic offset_case(input logic [31:0] w1, input logic [31:0] w2,
                             input logic exp_hit, input string nm);
    beat(32'h0,  1'b1, 32'h0, 1'b0,    {nm, "_clear"});
    beat(w1,     1'b0, 32'h0, 1'b0,    {nm, "_w1"});
    beat(w2,     1'b0, w1,    1'b0,    {nm, "_w2"});
    beat(32'h0,  1'b0, w2,    exp_hit, {nm, "_z1"});
    beat(32'h0,  1'b0, 32'h0, exp_hit, {nm, "_z2"});
  endtask

  task automatic test_offsets();
    ip_in = IP;
    offset_case(32'h01000000, 32'h00C0A801, 1'b1, "off1");
    offset_case(32'h01010000, 32'h0000C0A8, 1'b1, "off2");
    offset_case(32'hA8010100, 32'h000000C0, 1'b1, "off3");
  endtask

  task automatic test_negative();
    ip_in = IP;
    offset_case(32'hC0A80100, 32'h01C0A800, 1'b0, "neg_near");
    ip_in = 32'h0;
    beat(32'h0, 1'b1, 32'h0, 1'b0, "neg_zero_clear");
    for (int i = 0; i < 4; i++) beat(32'h0, 1'b0, 32'h0, 1'b0, "neg_zero_stream");
  endtask

  task automatic test_clear_sticky();
    ip_in = IP;
    beat(32'h0, 1'b1, 32'h0, 1'b0, "sticky_clear");
    beat(IP,    1'b0, 32'h0, 1'b0, "sticky_hit");
    beat(32'h0, 1'b0, IP,    1'b1, "sticky_set");
    for (int i = 0; i < 5; i++) beat(32'h0, 1'b0, 32'h0, 1'b1, "sticky_hold");
    ip_in = 32'h11111111;
    beat(32'h0, 1'b0, 32'h0, 1'b1, "sticky_ip_change");
    beat(32'h0, 1'b1, 32'h0, 1'b0, "sticky_pulse_clear");
    beat(32'h0, 1'b0, 32'h0, 1'b0, "sticky_after_clear");
    ip_in = IP;
    beat(IP,    1'b0, 32'h0, 1'b0, "clr_vs_hit_load");
    beat(32'h5, 1'b1, 32'h0, 1'b0, "clr_vs_hit_clear");
    beat(32'h0, 1'b0, 32'h0, 1'b0, "clr_vs_hit_after");
  endtask

  // Independent model: walk the eight most recent bytes in arrival order.
  function automatic logic model_hit(input logic [31:0] older, input logic [31:0] newer,
                                     input logic [31:0] ip);
    logic [7:0] b[8];
    for (int i = 0; i < 4; i++) begin
      b[i]     = older[8*i +: 8];
      b[i + 4] = newer[8*i +: 8];
    end
    model_hit = 1'b0;
    if (ip != 32'h0) begin
      for (int o = 0; o <= 4; o++) begin
        if ({b[o + 3], b[o + 2], b[o + 1], b[o]} == ip) model_hit = 1'b1;
      end
    end
  endfunction

  task automatic test_back_to_back();
    logic [7:0]  alphabet[4];
    logic [31:0] m_cur, m_prev, w, e_do;
    logic        m_match, clr, e_m;
    alphabet[0] = 8'hC0;
    alphabet[1] = 8'hA8;
    alphabet[2] = 8'h01;
    alphabet[3] = 8'h00;
    ip_in   = IP;
    m_cur   = 32'h0;
    m_prev  = 32'h0;
    m_match = 1'b0;
    beat(32'h0, 1'b1, 32'h0, 1'b0, "rand_clear");
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = alphabet[$urandom_range(3, 0)];
      clr = ($urandom_range(19, 0) == 0);
      if (clr) begin
        e_do    = 32'h0;
        e_m     = 1'b0;
        m_cur   = 32'h0;
        m_prev  = 32'h0;
        m_match = 1'b0;
      end else begin
        e_do    = m_cur;
        e_m     = m_match | model_hit(m_prev, m_cur, ip_in);
        m_prev  = m_cur;
        m_cur   = w;
        m_match = e_m;
      end
      beat(w, clr, e_do, e_m, "rand_stream");
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n_rst        = 1'b1;
    clear        = 1'b0;
    ip_in        = 32'h0;
    data_in      = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_aligned();
    test_offsets();
    test_negative();
    test_clear_sticky();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
